// File: rtl/sc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sc_pkg
//  Description : Shared types and sizing helpers for the slow-control chain
//                engine: FSM state encoding, readback mode constants and
//                functions deriving buffer depth and counter widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package sc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_GAP   = 3'd2,
        ST_LOAD  = 3'd3,
        ST_DONE  = 3'd4
    } sc_state_e;

    localparam logic SC_MODE_WRITE  = 1'b0;
    localparam logic SC_MODE_VERIFY = 1'b1;

    // Bytes needed to hold the whole chain bitstream.
    function automatic int sc_depth(input int total);
        return (total + 7) / 8;
    endfunction

    // Serial period counter: must reach 2*TOTAL. Kept at least 4 bits wide
    // so the low three bits can always serve as the bit-in-byte select.
    function automatic int sc_idx_w(input int total);
        int w;
        w = $clog2(2 * total + 1);
        return (w < 4) ? 4 : w;
    endfunction

    // GAP / LOAD phase timer width.
    function automatic int sc_tmr_w(input int clk_div, input int load_cycles);
        int w;
        w = $clog2(clk_div * 2 * load_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Byte address width for the configuration buffer.
    function automatic int sc_byte_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sc_clk_div.sv
`default_nettype none
// ============================================================================
//  Module      : sc_clk_div
//  Description : Half-period divider producing the registered serial clock.
//                Held in reset (sc_clk_o=0, counter cleared) while en_i is low.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk       in   system clock
//    rst       in   synchronous active-high reset
//    en_i      in   run enable; low forces sc_clk_o=0 on the next edge
//    sc_clk_o  out  registered serial clock
//    rise_o    out  high in the cycle whose closing edge raises sc_clk_o
//    fall_o    out  high in the cycle whose closing edge lowers sc_clk_o
// ============================================================================
module sc_clk_div
    import sc_pkg::*;
#(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic sc_clk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int              CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             clk_q;
    logic             wrap;

    // Strobes lead the edge by one cycle so the parent can update data on
    // the same edge that moves sc_clk.
    assign wrap   = en_i && (cnt_q == CNT_LAST);
    assign rise_o = wrap && !clk_q;
    assign fall_o = wrap &&  clk_q;

    always_ff @(posedge clk) begin
        if (rst || !en_i) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else if (wrap) begin
            cnt_q <= '0;
            clk_q <= ~clk_q;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign sc_clk_o = clk_q;

endmodule
`default_nettype wire

// File: rtl/sc_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sc_chain_ctrl
//  Description : Slow-control engine for daisy-chained front-end ASICs.
//                Buffers a byte-written bitstream, shifts it MSB-first into
//                the chain on a divided serial clock, optionally shifts it a
//                second time to verify readback, then pulses sc_load.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, rst      system clock, synchronous active-high reset
//    wr_en/sc_data byte write into the configuration buffer
//    buf_clr       reset write pointer and overflow flag
//    sc_start      start pulse (IDLE only), verify sampled with it
//    sc_abort      abort SHIFT/GAP/LOAD
//    sc_data_back  serial output of the last ASIC in the chain
//    sc_dout/sc_clk/sc_rstb/sc_load   ASIC slow-control pins
//    sc_busy/sc_done                  transfer status
//    verify_err/err_count             readback result
//    wr_overflow                      sticky write-past-end flag
// ============================================================================
module sc_chain_ctrl
    import sc_pkg::*;
#(
    parameter int DATA_LENGTH = 929,
    parameter int N_CHAIN     = 1,
    parameter int CLK_DIV     = 20,
    parameter int LOAD_CYCLES = 2,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       sc_data,
    input  logic             buf_clr,
    input  logic             sc_start,
    input  logic             verify,
    input  logic             sc_abort,
    input  logic             sc_data_back,
    output logic             sc_dout,
    output logic             sc_clk,
    output logic             sc_rstb,
    output logic             sc_load,
    output logic             sc_busy,
    output logic             sc_done,
    output logic             verify_err,
    output logic [ERR_W-1:0] err_count,
    output logic             wr_overflow
);

    localparam int TOTAL  = DATA_LENGTH * N_CHAIN;
    localparam int DEPTH  = sc_depth(TOTAL);
    localparam int PTR_W  = $clog2(DEPTH + 1);
    localparam int BYTE_W = sc_byte_w(DEPTH);
    localparam int IDX_W  = sc_idx_w(TOTAL);
    localparam int TMR_W  = sc_tmr_w(CLK_DIV, LOAD_CYCLES);

    localparam logic [IDX_W-1:0] TOTAL_V   = IDX_W'(TOTAL);
    localparam logic [IDX_W-1:0] TOTAL2_V  = IDX_W'(2 * TOTAL);
    localparam logic [PTR_W-1:0] DEPTH_V   = PTR_W'(DEPTH);
    localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(2 * CLK_DIV - 1);
    localparam logic [TMR_W-1:0] LOAD_LAST = TMR_W'(LOAD_CYCLES * 2 * CLK_DIV - 1);

    sc_state_e        state_q, state_d;

    logic [7:0]       buf_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic             wr_ovf_q;

    logic             verify_q;
    logic [IDX_W-1:0] rise_cnt_q;      // sc_clk rising edges seen this transfer
    logic [IDX_W-1:0] len;
    logic [TMR_W-1:0] tmr_q;
    logic             dout_q;
    logic             rstb_q;
    logic             verr_q;
    logic [ERR_W-1:0] err_q;

    logic             div_en, div_clk, div_rise, div_fall;
    logic             accept;

    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       rd_byte;
    logic             rd_bit;

    // ------------------------------------------------------------------
    // Configuration buffer. Writes are only taken while idle so a running
    // transfer always sees a stable image.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            wr_ovf_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else if (buf_clr) begin
            wr_ptr_q <= '0;
            wr_ovf_q <= 1'b0;
        end else if (wr_en && (state_q == ST_IDLE)) begin
            if (wr_ptr_q == DEPTH_V) begin
                wr_ovf_q <= 1'b1;
            end else begin
                buf_q[wr_ptr_q[BYTE_W-1:0]] <= sc_data;
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
        end
    end

    // The same buffer bit serves both the next outgoing bit (index r mod
    // TOTAL) and the expected readback bit (index r-TOTAL), so one read
    // port indexed by the rising-edge count covers both.
    always_comb begin
        rd_idx  = (rise_cnt_q >= TOTAL_V) ? (rise_cnt_q - TOTAL_V) : rise_cnt_q;
        rd_byte = buf_q[BYTE_W'(rd_idx >> 3)];
        rd_bit  = rd_byte[~rd_idx[2:0]];
    end

    assign len = (verify_q == SC_MODE_VERIFY) ? TOTAL2_V : TOTAL_V;

    // Abort drops the enable immediately so sc_clk is low on the next cycle.
    assign div_en = (state_q == ST_SHIFT) && !sc_abort;

    sc_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk      (clk),
        .rst      (rst),
        .en_i     (div_en),
        .sc_clk_o (div_clk),
        .rise_o   (div_rise),
        .fall_o   (div_fall)
    );

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sc_start) begin
                    accept  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sc_abort) begin
                    state_d = ST_IDLE;
                end else if (div_fall && (rise_cnt_q == len)) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (sc_abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == GAP_LAST) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (sc_abort) begin
                    state_d = ST_IDLE;
                end else if (tmr_q == LOAD_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register and shift/readback datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rstb_q     <= 1'b0;
            tmr_q      <= '0;
            rise_cnt_q <= '0;
            dout_q     <= 1'b0;
            verify_q   <= SC_MODE_WRITE;
            err_q      <= '0;
            verr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            rstb_q  <= 1'b1;

            // Phase timer restarts on every state change.
            if ((state_d == state_q) && ((state_q == ST_GAP) || (state_q == ST_LOAD))) begin
                tmr_q <= tmr_q + TMR_W'(1);
            end else begin
                tmr_q <= '0;
            end

            if (accept) begin
                rise_cnt_q <= '0;
                verify_q   <= verify;
                err_q      <= '0;
                verr_q     <= 1'b0;
                dout_q     <= buf_q[0][7];
            end else if (state_q == ST_SHIFT) begin
                if (state_d != ST_SHIFT) begin
                    dout_q <= 1'b0;
                end else begin
                    if (div_rise) begin
                        rise_cnt_q <= rise_cnt_q + IDX_W'(1);
                    end
                    if (div_fall) begin
                        dout_q <= rd_bit;
                    end
                end
                // Readback: after rising edge r (TOTAL <= r < 2*TOTAL) the
                // last ASIC presents the bit shifted in at period r-TOTAL.
                if (div_fall && (verify_q == SC_MODE_VERIFY) &&
                    (rise_cnt_q >= TOTAL_V) && (rise_cnt_q != len) &&
                    (sc_data_back != rd_bit)) begin
                    verr_q <= 1'b1;
                    if (err_q != {ERR_W{1'b1}}) begin
                        err_q <= err_q + ERR_W'(1);
                    end
                end
            end
        end
    end

    assign sc_dout     = dout_q;
    assign sc_clk      = div_clk;
    assign sc_rstb     = rstb_q;
    assign sc_load     = (state_q == ST_LOAD);
    assign sc_busy     = (state_q != ST_IDLE);
    assign sc_done     = (state_q == ST_DONE);
    assign verify_err  = verr_q;
    assign err_count   = err_q;
    assign wr_overflow = wr_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_chain_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_chain_ctrl
//  Description : Directed self-checking bench. Instance d1 is a 12-bit
//                single-ASIC chain; d2 is a 2 x 12-bit chain with a 2-bit
//                error counter, driven against a 24-bit shift-register model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_chain_ctrl;

    localparam int PERIOD1 = 4;   // 2*CLK_DIV clk cycles per sc_clk period

    logic clk = 1'b0;
    logic rst, wr_en, buf_clr, verify, sc_abort;
    logic [7:0] sc_data;
    logic start1, start2;
    logic back1, back2;

    logic o1_dout, o1_clk, o1_rstb, o1_load, o1_busy, o1_done, o1_verr, o1_ovf;
    logic [15:0] o1_err;
    logic o2_dout, o2_clk, o2_rstb, o2_load, o2_busy, o2_done, o2_verr, o2_ovf;
    logic [1:0] o2_err;

    always #5 clk = ~clk;

    sc_chain_ctrl #(.DATA_LENGTH(12), .N_CHAIN(1), .CLK_DIV(2), .LOAD_CYCLES(2), .ERR_W(16)) u_d1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .sc_data(sc_data), .buf_clr(buf_clr),
        .sc_start(start1), .verify(verify), .sc_abort(sc_abort), .sc_data_back(back1),
        .sc_dout(o1_dout), .sc_clk(o1_clk), .sc_rstb(o1_rstb), .sc_load(o1_load),
        .sc_busy(o1_busy), .sc_done(o1_done), .verify_err(o1_verr), .err_count(o1_err),
        .wr_overflow(o1_ovf)
    );

    sc_chain_ctrl #(.DATA_LENGTH(12), .N_CHAIN(2), .CLK_DIV(2), .LOAD_CYCLES(2), .ERR_W(2)) u_d2 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .sc_data(sc_data), .buf_clr(buf_clr),
        .sc_start(start2), .verify(verify), .sc_abort(sc_abort), .sc_data_back(back2),
        .sc_dout(o2_dout), .sc_clk(o2_clk), .sc_rstb(o2_rstb), .sc_load(o2_load),
        .sc_busy(o2_busy), .sc_done(o2_done), .verify_err(o2_verr), .err_count(o2_err),
        .wr_overflow(o2_ovf)
    );

    // ---------------- monitors (sampled on the falling clk edge) ----------
    int   cyc = 0;
    int   rise1 = 0, badgap1 = 0, last_rise1 = 0, last_fall1 = 0;
    int   load1 = 0, load_start1 = 0, done1 = 0, done_cyc1 = 0;
    logic p1_clk = 1'b0, p1_load = 1'b0, first1 = 1'b1;
    logic [11:0] cap1 = '0;
    int   rise2 = 0, done2 = 0;
    logic p2_clk = 1'b0;
    logic [23:0] chain2 = '0;

    // Readback fault injection on d2: 1 = invert readback bit 5, 2 = invert all.
    int inj_mode = 0;
    int base2 = 0;
    assign back1 = 1'b0;
    assign back2 = chain2[23] ^ (((inj_mode == 1) && ((rise2 - base2) == 29)) ||
                                 ((inj_mode == 2) && ((rise2 - base2) >= 24)));

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        p1_clk  <= o1_clk;
        p1_load <= o1_load;
        if (!o1_busy) first1 <= 1'b1;
        if (o1_clk && !p1_clk) begin
            rise1 <= rise1 + 1;
            cap1  <= {cap1[10:0], o1_dout};
            if (!first1 && ((cyc - last_rise1) != PERIOD1)) badgap1 <= badgap1 + 1;
            last_rise1 <= cyc;
            first1     <= 1'b0;
        end
        if (!o1_clk && p1_clk) last_fall1 <= cyc;
        if (o1_load) load1 <= load1 + 1;
        if (o1_load && !p1_load) load_start1 <= cyc;
        if (o1_done) begin
            done1     <= done1 + 1;
            done_cyc1 <= cyc;
        end
    end

    // d2 chain model: each ASIC stage captures on the serial clock rise.
    always @(negedge clk) begin
        p2_clk <= o2_clk;
        if (o2_clk && !p2_clk) begin
            rise2  <= rise2 + 1;
            chain2 <= {chain2[22:0], o2_dout};
        end
        if (o2_done) done2 <= done2 + 1;
    end

    // ---------------- helpers ----------------
    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        sc_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic start_dut(input int which, input logic v);
        verify = v;
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_idle(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if ((which == 1) ? !o1_busy : !o2_busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        int r0, l0, d0, e0;

        rst = 1'b1; wr_en = 1'b0; buf_clr = 1'b0; verify = 1'b0; sc_abort = 1'b0;
        sc_data = 8'h00; start1 = 1'b0; start2 = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_clk",   o1_clk,  1'b0);
        check("rst_dout",  o1_dout, 1'b0);
        check("rst_busy",  o1_busy, 1'b0);
        check("rst_load",  o1_load, 1'b0);
        check("rst_rstb",  o1_rstb, 1'b0);
        check("rst_err",   o2_err,  2'd0);
        check("rst_ovf",   o1_ovf,  1'b0);
        rst = 1'b0;
        tick();
        check("rstb_release", o1_rstb, 1'b1);

        // 1. Write-only transfer on d1
        wr_byte(8'hA5);
        wr_byte(8'h3C);
        r0 = rise1; l0 = load1; d0 = done1;
        start_dut(1, 1'b0);
        check("s1_busy_after_start", o1_busy, 1'b1);
        wait_idle(1, ok);
        check("s1_complete", ok, 1'b1);
        check("s1_rises", rise1 - r0, 12);
        check("s1_stream", cap1, 12'hA53);
        check("s1_rise_spacing_bad", badgap1, 0);
        check("s1_gap_len", load_start1 - last_fall1, 4);
        check("s1_load_len", load1 - l0, 8);
        check("s1_done_after_load", done_cyc1 - load_start1, 8);
        check("s1_done_pulses", done1 - d0, 1);
        check("s1_err_count", o1_err, 16'd0);
        check("s1_verify_err", o1_verr, 1'b0);

        // Third byte: fills d2 (DEPTH 3), overflows d1 (DEPTH 2)
        wr_byte(8'h96);
        check("ovf_d1_set", o1_ovf, 1'b1);
        check("ovf_d2_clear", o2_ovf, 1'b0);

        // 2. Verify pass on d2
        r0 = rise2; d0 = done2;
        start_dut(2, 1'b1);
        wait_idle(2, ok);
        check("s2_complete", ok, 1'b1);
        check("s2_rises", rise2 - r0, 48);
        check("s2_chain", chain2, 24'hA53C96);
        check("s2_err_count", o2_err, 2'd0);
        check("s2_verify_err", o2_verr, 1'b0);
        check("s2_done_pulses", done2 - d0, 1);

        // 3. Verify with readback bit 5 inverted
        inj_mode = 1; base2 = rise2;
        start_dut(2, 1'b1);
        wait_idle(2, ok);
        check("s3_complete", ok, 1'b1);
        check("s3_err_count", o2_err, 2'd1);
        check("s3_verify_err", o2_verr, 1'b1);
        check("s3_chain", chain2, 24'hA53C96);

        // Saturation: every readback bit wrong, 2-bit counter stops at 3
        inj_mode = 2; base2 = rise2;
        start_dut(2, 1'b1);
        check("sat_err_cleared_on_start", o2_err, 2'd0);
        check("sat_verr_cleared_on_start", o2_verr, 1'b0);
        wait_idle(2, ok);
        check("sat_complete", ok, 1'b1);
        check("sat_err_count", o2_err, 2'd3);
        check("sat_verify_err", o2_verr, 1'b1);
        inj_mode = 0;

        // 4. Start together with abort in IDLE: start wins; abort after 7 rises
        r0 = rise1;
        sc_abort = 1'b1;
        start_dut(1, 1'b0);
        sc_abort = 1'b0;
        check("s4_start_beats_abort", o1_busy, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ((rise1 - r0) >= 7) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("s4_reach_7_rises", ok, 1'b1);
        l0 = load1; d0 = done1;
        sc_abort = 1'b1;
        tick();
        sc_abort = 1'b0;
        check("s4_abort_busy", o1_busy, 1'b0);
        check("s4_abort_clk", o1_clk, 1'b0);
        check("s4_abort_load", o1_load, 1'b0);
        repeat (30) tick();
        check("s4_no_load", load1 - l0, 0);
        check("s4_no_done", done1 - d0, 0);

        // Full rerun; a second start while busy must be ignored
        r0 = rise1; d0 = done1;
        start_dut(1, 1'b0);
        repeat (10) tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_idle(1, ok);
        check("s4_rerun_complete", ok, 1'b1);
        check("s4_rerun_rises", rise1 - r0, 12);
        check("s4_rerun_stream", cap1, 12'hA53);
        check("s4_rerun_done", done1 - d0, 1);

        // 5. buf_clr clears overflow; clear beats a simultaneous write
        buf_clr = 1'b1;
        tick();
        buf_clr = 1'b0;
        check("s5_ovf_cleared", o1_ovf, 1'b0);
        buf_clr = 1'b1; wr_en = 1'b1; sc_data = 8'hFF;
        tick();
        buf_clr = 1'b0; wr_en = 1'b0;
        wr_byte(8'h5A);
        start_dut(1, 1'b0);
        wait_idle(1, ok);
        check("s5_complete", ok, 1'b1);
        check("s5_stream_byte0", cap1, 12'h5A3);

        // 6. Reset during LOAD
        d0 = done1;
        start_dut(1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (o1_load) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("s6_reach_load", ok, 1'b1);
        rst = 1'b1;
        tick();
        e0 = {o1_clk, o1_dout, o1_load, o1_busy, o1_done, o1_verr, o1_ovf, o1_rstb};
        check("s6_outputs_reset", e0, 0);
        check("s6_err_reset", o1_err, 16'd0);
        rst = 1'b0;
        check("s6_rstb_low_until_edge", o1_rstb, 1'b0);
        tick();
        check("s6_rstb_release", o1_rstb, 1'b1);
        repeat (20) tick();
        check("s6_no_done", done1 - d0, 0);
        check("s6_idle", o1_busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
